// File: rtl/ram_arb.sv
// ram_arb: two-master arbiter in front of one port of a byte-enabled RAM.
//
// A grant is combinational. When master X is granted, its request appears on
// the RAM port in the same cycle. The RAM returns registered read data one
// cycle later, and mX_rvalid marks that cycle for reads and writes alike.
// While the other master is also requesting, one master can hold the port
// for at most BURST consecutive grants. Contention from IDLE is resolved by
// a prio bit that always points at the master that lost the last grant.
//
// Handshake: a master raises mX_req and keeps req/addr/wdata/we stable until
// the cycle mX_gnt is high. The access completes in that cycle. mX_rvalid
// pulses exactly one cycle later, with mX_rdata carrying ram_rdata.
//
// Parameters
//   SCALE  RAM byte-address width (2**SCALE bytes)
//   BURST  max consecutive grants to one master under contention (1..15)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   mX_req/addr/wdata/we     master X request (we == 0 means read)
//   mX_gnt/rvalid/rdata      master X grant and read return
//   ram_oe/addr/wdata/we     RAM port command (all zero with no grant)
//   ram_rdata                RAM registered read data
//   dbg_state_o              FSM state: 0 IDLE, 1 OWN0, 2 OWN1
//   dbg_run_o, dbg_prio_o    run counter and prio register
//
// Optional feature: define RAM_ARB_PROTOCOL_CHECK_EN to add a
// simulation-only protocol checker. It stops the simulation on an unstable
// pending request, an illegal byte-enable pattern or an out-of-range BURST.

module ram_arb #(
    parameter int SCALE = 10,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic [SCALE-1:0] m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_we,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [31:0]      m0_rdata,
    input  logic             m1_req,
    input  logic [SCALE-1:0] m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_we,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [31:0]      m1_rdata,
    output logic             ram_oe,
    output logic [SCALE-1:0] ram_addr,
    output logic [31:0]      ram_wdata,
    output logic [3:0]       ram_we,
    input  logic [31:0]      ram_rdata,
    output logic [1:0]       dbg_state_o,
    output logic [3:0]       dbg_run_o,
    output logic             dbg_prio_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    localparam logic [3:0] BURST_L = 4'(BURST);

    state_e     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic       prio_q, prio_d;      // 0 selects m0, 1 selects m1
    logic       rvalid0_q, rvalid1_q;

    logic       gnt0_c, gnt1_c;
    logic       run_below;
    logic [3:0] run_inc;

    assign run_below = (run_q < BURST_L);
    assign run_inc   = (run_q == 4'hF) ? 4'hF : run_q + 4'd1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            run_q   <= 4'd0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            prio_q  <= prio_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic, including the grant decision
    // ------------------------------------------------------------------
    always_comb begin
        gnt0_c  = 1'b0;
        gnt1_c  = 1'b0;
        state_d = ST_IDLE;
        run_d   = 4'd0;
        prio_d  = prio_q;

        // No grant is issued while reset is asserted.
        if (!rst) begin
            if (m0_req && !m1_req) begin
                gnt0_c = 1'b1;
            end else if (m1_req && !m0_req) begin
                gnt1_c = 1'b1;
            end else if (m0_req && m1_req) begin
                case (state_q)
                    ST_OWN0: begin
                        if (run_below) gnt0_c = 1'b1;
                        else           gnt1_c = 1'b1;
                    end
                    ST_OWN1: begin
                        if (run_below) gnt1_c = 1'b1;
                        else           gnt0_c = 1'b1;
                    end
                    default: begin
                        if (prio_q) gnt1_c = 1'b1;
                        else        gnt0_c = 1'b1;
                    end
                endcase
            end
        end

        // The run counter counts consecutive grants to the current owner.
        // It restarts at 1 when ownership changes or when leaving IDLE.
        if (gnt0_c) begin
            state_d = ST_OWN0;
            run_d   = (state_q == ST_OWN0) ? run_inc : 4'd1;
            prio_d  = 1'b1;
        end else if (gnt1_c) begin
            state_d = ST_OWN1;
            run_d   = (state_q == ST_OWN1) ? run_inc : 4'd1;
            prio_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        m0_gnt    = gnt0_c;
        m1_gnt    = gnt1_c;
        ram_oe    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = '0;
        if (gnt0_c) begin
            ram_oe    = 1'b1;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
            ram_we    = m0_we;
        end else if (gnt1_c) begin
            ram_oe    = 1'b1;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
            ram_we    = m1_we;
        end
        m0_rvalid   = rvalid0_q;
        m1_rvalid   = rvalid1_q;
        m0_rdata    = rvalid0_q ? ram_rdata : 32'h0;
        m1_rdata    = rvalid1_q ? ram_rdata : 32'h0;
        dbg_state_o = state_q;
        dbg_run_o   = run_q;
        dbg_prio_o  = prio_q;
    end

    // Response tracking. An asynchronous reset drops any response that is
    // still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0_c;
            rvalid1_q <= gnt1_c;
        end
    end

`ifdef RAM_ARB_PROTOCOL_CHECK_EN
    // ------------------------------------------------------------------
    // Simulation-only protocol checker
    // ------------------------------------------------------------------
    logic             c_req   [2];
    logic             c_gnt   [2];
    logic [SCALE-1:0] c_addr  [2];
    logic [31:0]      c_wdata [2];
    logic [3:0]       c_we    [2];

    logic             p_pend_q  [2];
    logic [SCALE-1:0] p_addr_q  [2];
    logic [31:0]      p_wdata_q [2];
    logic [3:0]       p_we_q    [2];
    int unsigned      cyc_q;

    always_comb begin
        c_req[0]   = m0_req;
        c_gnt[0]   = gnt0_c;
        c_addr[0]  = m0_addr;
        c_wdata[0] = m0_wdata;
        c_we[0]    = m0_we;
        c_req[1]   = m1_req;
        c_gnt[1]   = gnt1_c;
        c_addr[1]  = m1_addr;
        c_wdata[1] = m1_wdata;
        c_we[1]    = m1_we;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= 0;
            for (int m = 0; m < 2; m++) begin
                p_pend_q[m]  <= 1'b0;
                p_addr_q[m]  <= '0;
                p_wdata_q[m] <= '0;
                p_we_q[m]    <= '0;
            end
        end else begin
            cyc_q <= cyc_q + 1;
            if (BURST < 1 || BURST > 15) begin
                $display("ram_arb protocol: cycle %0d master none: BURST=%0d out of range",
                         cyc_q, BURST);
                $finish;
            end
            for (int m = 0; m < 2; m++) begin
                // A request left ungranted last cycle must be presented again unchanged.
                if (p_pend_q[m] && (!c_req[m] || c_addr[m] != p_addr_q[m] ||
                    c_wdata[m] != p_wdata_q[m] || c_we[m] != p_we_q[m])) begin
                    $display("ram_arb protocol: cycle %0d master m%0d changed a pending request",
                             cyc_q, m);
                    $finish;
                end
                if (c_req[m] && !(c_we[m] == 4'b0000 || c_we[m] == 4'b0001 ||
                                  c_we[m] == 4'b0011 || c_we[m] == 4'b1111)) begin
                    $display("ram_arb protocol: cycle %0d master m%0d illegal we=%b",
                             cyc_q, m, c_we[m]);
                    $finish;
                end
                p_pend_q[m]  <= c_req[m] && !c_gnt[m];
                p_addr_q[m]  <= c_addr[m];
                p_wdata_q[m] <= c_wdata[m];
                p_we_q[m]    <= c_we[m];
            end
        end
    end
`else
    // Checker disabled: no extra logic.
`endif

endmodule

// File: tb/tb_ram_arb.sv
module tb_ram_arb;
  localparam int SCALE = 10;
  localparam int BURST = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- master drivers ----------------
  logic             bm_req   [2];
  logic [SCALE-1:0] bm_addr  [2];
  logic [31:0]      bm_wdata [2];
  logic [3:0]       bm_we    [2];

  logic             m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]      m0_rdata, m1_rdata;
  logic             ram_oe;
  logic [SCALE-1:0] ram_addr;
  logic [31:0]      ram_wdata;
  logic [3:0]       ram_we;
  logic [31:0]      ram_rdata;
  logic [1:0]       dbg_state;
  logic [3:0]       dbg_run;
  logic             dbg_prio;

  ram_arb #(.SCALE(SCALE), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .m0_req(bm_req[0]), .m0_addr(bm_addr[0]), .m0_wdata(bm_wdata[0]), .m0_we(bm_we[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(bm_req[1]), .m1_addr(bm_addr[1]), .m1_wdata(bm_wdata[1]), .m1_we(bm_we[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_oe(ram_oe), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata),
    .dbg_state_o(dbg_state), .dbg_run_o(dbg_run), .dbg_prio_o(dbg_prio)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- memory helpers ----------------
  function automatic logic [31:0] pat(int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hA5, b, ~b, 8'h3C};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural RAM on the DUT's RAM port (registered read, read-before-write)
  bit [31:0]   tb_mem [256];
  bit          tb_wr  [256];
  int          tb_i;
  logic [31:0] tb_base;
  always @(posedge clk) begin
    if (ram_oe) begin
      tb_i = int'(ram_addr[9:2]);
      tb_base = tb_wr[tb_i] ? tb_mem[tb_i] : pat(tb_i);
      ram_rdata <= tb_base;
      tb_mem[tb_i] <= merge(tb_base, ram_wdata, ram_we);
      tb_wr[tb_i] <= 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // last: -1 after an idle cycle, else the master granted last cycle.
  int          mdl_last;
  int          mdl_run;
  int          mdl_prio;
  bit          mdl_rv [2];
  logic [31:0] mdl_rd [2];
  bit [31:0]   ref_mem [256];
  bit          ref_wr  [256];

  task automatic model_reset();
    mdl_last = -1;
    mdl_run = 0;
    mdl_prio = 0;
    mdl_rv[0] = 1'b0;
    mdl_rv[1] = 1'b0;
  endtask

  function automatic int model_grant();
    if (rst) return -1;
    if (bm_req[0] && !bm_req[1]) return 0;
    if (bm_req[1] && !bm_req[0]) return 1;
    if (!bm_req[0] && !bm_req[1]) return -1;
    if (mdl_last < 0) return mdl_prio;
    if (mdl_run < BURST) return mdl_last;
    return 1 - mdl_last;
  endfunction

  task automatic model_commit(input int g);
    int idx;
    logic [31:0] old;
    mdl_rv[0] = (g == 0);
    mdl_rv[1] = (g == 1);
    if (g < 0) begin
      mdl_last = -1;
      mdl_run = 0;
      return;
    end
    idx = int'(bm_addr[g][9:2]);
    old = ref_wr[idx] ? ref_mem[idx] : pat(idx);
    mdl_rd[g] = old;
    ref_mem[idx] = merge(old, bm_wdata[g], bm_we[g]);
    ref_wr[idx] = 1'b1;
    mdl_run = (g == mdl_last) ? ((mdl_run < 15) ? mdl_run + 1 : 15) : 1;
    mdl_last = g;
    mdl_prio = 1 - g;
  endtask

  function automatic logic [48:0] exp_ram(int g);
    if (g < 0) return '0;
    return {g == 0, g == 1, 1'b1, bm_we[g], bm_addr[g], bm_wdata[g]};
  endfunction

  function automatic logic [65:0] exp_rsp();
    return {mdl_rv[0], mdl_rv[1], mdl_rv[0] ? mdl_rd[0] : 32'h0, mdl_rv[1] ? mdl_rd[1] : 32'h0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle(input int m);
    bm_req[m] = 1'b0;
    bm_addr[m] = '0;
    bm_wdata[m] = '0;
    bm_we[m] = '0;
  endtask

  task automatic set_req(input int m, input logic [SCALE-1:0] a, input logic [31:0] d,
                         input logic [3:0] w);
    bm_req[m] = 1'b1;
    bm_addr[m] = a;
    bm_wdata[m] = d;
    bm_we[m] = w;
  endtask

  function automatic logic [SCALE-1:0] rand_addr();
    logic [3:0] w;
    w = 4'($urandom_range(0, 15));
    return {4'b0000, w, 2'b00};
  endfunction

  function automatic logic [3:0] rand_we();
    case ($urandom_range(0, 4))
      0, 1:    return 4'b0000;
      2:       return 4'b0001;
      3:       return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Advance one clock: model commits the grant decided by the current inputs.
  task automatic tick();
    int g;
    g = model_grant();
    @(posedge clk);
    model_commit(g);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle(0);
    set_idle(1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_req(0, 10'h010, 32'h1111_2222, 4'b1111);
    set_req(1, 10'h020, 32'h3333_4444, 4'b0000);
    #3;
    n_vec++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt});
    end
    n_vec++;
    if ({ram_oe, ram_we, ram_addr, ram_wdata} !== 47'h0) begin
      n_err++;
      $display("FAIL reset_ram: got %h want 0", {ram_oe, ram_we, ram_addr, ram_wdata});
    end
    n_vec++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 66'h0) begin
      n_err++;
      $display("FAIL reset_rsp: got %h want 0", {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata});
    end
    n_vec++;
    if ({dbg_state, dbg_run, dbg_prio} !== 7'h0) begin
      n_err++;
      $display("FAIL reset_fsm: got state=%0d run=%0d prio=%0d want 0/0/0",
               dbg_state, dbg_run, dbg_prio);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_idle(0);
    set_idle(1);
    model_reset();
  endtask

  task automatic test_single_read();
    set_req(0, 10'h010, 32'h0, 4'b0000);
    #3;
    n_vec++;
    if ({m0_gnt, m1_gnt, ram_oe, ram_addr, ram_we} !== {3'b101, 10'h010, 4'b0000}) begin
      n_err++;
      $display("FAIL single_read_cmd: got gnt=%b oe=%b addr=%h we=%b want 10 1 010 0000",
               {m0_gnt, m1_gnt}, ram_oe, ram_addr, ram_we);
    end
    tick();
    set_idle(0);
    #3;
    n_vec++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, pat(4)}) begin
      n_err++;
      $display("FAIL single_read_rsp: got rv=%b rdata=%h want 10 %h",
               {m0_rvalid, m1_rvalid}, m0_rdata, pat(4));
    end
    n_vec++;
    if ({m0_gnt, m1_gnt, ram_oe} !== 3'b000) begin
      n_err++;
      $display("FAIL single_read_idle: got %b want 000", {m0_gnt, m1_gnt, ram_oe});
    end
    tick();
  endtask

  task automatic test_contention();
    bit got [2];
    int g;
    do_reset();
    got[0] = 1'b0;
    got[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (got[m]) set_idle(m);
        else if (!bm_req[m]) set_req(m, rand_addr(), $urandom, 4'b0000);
      end
      #3;
      n_vec++;
      if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL contention_order[%0d]: got %b want %b", i, {m0_gnt, m1_gnt},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      g = model_grant();
      n_vec++;
      if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== exp_rsp()) begin
        n_err++;
        $display("FAIL contention_rsp[%0d]: got %h want %h", i,
                 {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata}, exp_rsp());
      end
      got[0] = (g == 0);
      got[1] = (g == 1);
      tick();
    end
    set_idle(0);
    set_idle(1);
    tick();
  endtask

  task automatic test_burst();
    bit got [2];
    int g;
    logic [1:0] want;
    set_idle(0);
    set_idle(1);
    tick();
    got[0] = 1'b0;
    got[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (got[0] || !bm_req[0]) set_req(0, rand_addr(), $urandom, 4'b0000);
      if (got[1]) set_idle(1);
      else if (i >= 2 && !bm_req[1]) set_req(1, rand_addr(), $urandom, 4'b0000);
      #3;
      want = (i == 4) ? 2'b01 : 2'b10;
      n_vec++;
      if ({m0_gnt, m1_gnt} !== want) begin
        n_err++;
        $display("FAIL burst_gnt[%0d]: got %b want %b", i, {m0_gnt, m1_gnt}, want);
      end
      if (i == 4) begin
        n_vec++;
        if (dbg_run !== 4'd4) begin
          n_err++;
          $display("FAIL burst_run_full: got %0d want 4", dbg_run);
        end
      end
      if (i == 5) begin
        n_vec++;
        if ({dbg_state, dbg_run} !== {2'd2, 4'd1}) begin
          n_err++;
          $display("FAIL burst_switch: got state=%0d run=%0d want 2/1", dbg_state, dbg_run);
        end
      end
      g = model_grant();
      got[0] = (g == 0);
      got[1] = (g == 1);
      tick();
    end
    set_idle(0);
    set_idle(1);
    tick();
  endtask

  task automatic test_write_read();
    set_req(1, 10'h020, 32'hDEAD_BEEF, 4'b1111);
    #3;
    n_vec++;
    if ({m0_gnt, m1_gnt, ram_oe, ram_we, ram_addr, ram_wdata} !==
        {3'b011, 4'b1111, 10'h020, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL write_cmd: got %h want %h",
               {m0_gnt, m1_gnt, ram_oe, ram_we, ram_addr, ram_wdata},
               {3'b011, 4'b1111, 10'h020, 32'hDEAD_BEEF});
    end
    tick();
    set_idle(1);
    set_req(0, 10'h020, 32'h0, 4'b0000);
    #3;
    n_vec++;
    if ({m1_rvalid, m0_rvalid, m0_gnt} !== 3'b101) begin
      n_err++;
      $display("FAIL write_rvalid: got m1_rv/m0_rv/m0_gnt=%b want 101",
               {m1_rvalid, m0_rvalid, m0_gnt});
    end
    tick();
    set_idle(0);
    #3;
    n_vec++;
    if ({m1_rvalid, m0_rvalid, m0_rdata} !== {2'b01, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL read_back: got m1_rv=%b m0_rv=%b rdata=%h want 0 1 deadbeef",
               m1_rvalid, m0_rvalid, m0_rdata);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    set_req(0, 10'h010, 32'h0, 4'b0000);
    #3;
    n_vec++;
    if (m0_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL inflight_gnt: got %b want 1", m0_gnt);
    end
    tick();
    rst = 1'b1;
    set_req(0, rand_addr(), $urandom, 4'b0000);
    set_req(1, rand_addr(), $urandom, 4'b0000);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      #3;
      n_vec++;
      if ({m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, ram_oe} !== 5'b0) begin
        n_err++;
        $display("FAIL inflight_in_reset[%0d]: got %b want 00000", i,
                 {m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, ram_oe});
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_reset();
    #3;
    n_vec++;
    if ({m0_rvalid, dbg_state, m0_gnt, m1_gnt} !== {1'b0, 2'd0, 2'b10}) begin
      n_err++;
      $display("FAIL inflight_release: got rv=%b state=%0d gnt=%b want 0 0 10",
               m0_rvalid, dbg_state, {m0_gnt, m1_gnt});
    end
    tick();
    set_idle(0);
    #3;
    n_vec++;
    if ({m0_rvalid, m1_gnt} !== 2'b11) begin
      n_err++;
      $display("FAIL inflight_after: got rv0/gnt1=%b want 11", {m0_rvalid, m1_gnt});
    end
    tick();
    set_idle(1);
    tick();
  endtask

  task automatic test_random();
    bit got [2];
    int g;
    got[0] = 1'b0;
    got[1] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (got[m] || !bm_req[m]) begin
          if ($urandom_range(0, 9) < 7) set_req(m, rand_addr(), $urandom, rand_we());
          else set_idle(m);
        end
      end
      #3;
      g = model_grant();
      n_vec++;
      if ({m0_gnt, m1_gnt, ram_oe, ram_we, ram_addr, ram_wdata} !== exp_ram(g)) begin
        n_err++;
        $display("FAIL random_cmd[%0d]: got %h want %h", i,
                 {m0_gnt, m1_gnt, ram_oe, ram_we, ram_addr, ram_wdata}, exp_ram(g));
      end
      n_vec++;
      if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== exp_rsp()) begin
        n_err++;
        $display("FAIL random_rsp[%0d]: got %h want %h", i,
                 {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata}, exp_rsp());
      end
      got[0] = (g == 0);
      got[1] = (g == 1);
      tick();
    end
    set_idle(0);
    set_idle(1);
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_idle(0);
    set_idle(1);
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_contention();
    test_burst();
    test_write_read();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
